// File: rtl/demux_frame_ctrl.sv
// demux_frame_ctrl: receives framed serial bits (2-bit address header + payload)
// and steers each payload bit through the 1-to-4 demux, counting completed frames per channel.
module demux_frame_ctrl #(
    parameter int PAYLOAD_LEN = 8,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic                 rx_bit,
    input  logic                 start,
    output logic                 in,
    output logic                 sel1,
    output logic                 sel2,
    output logic                 route_valid,
    output logic                 frame_done,
    output logic                 err,
    output logic                 busy,
    output logic [4*CNT_W-1:0]   ch_count
);
    localparam int PW = $clog2(PAYLOAD_LEN + 1);

    typedef enum logic [1:0] {IDLE, ADDR1, PAYLOAD} state_t;

    state_t                   state, state_nx;
    logic                     msb;
    logic [PW-1:0]            pcnt;
    logic [3:0][CNT_W-1:0]    cnt;
    logic                     last;

    assign last     = pcnt == PW'(PAYLOAD_LEN - 1);
    assign busy     = state != IDLE;
    assign ch_count = cnt;

    // start always (re)opens a frame, aborting any frame in flight
    always_comb begin
        state_nx = state;
        if (rx_valid) begin
            if (start) state_nx = ADDR1;
            else if (state == ADDR1) state_nx = PAYLOAD;
            else if (state == PAYLOAD && last) state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            msb         <= 1'b0;
            sel1        <= 1'b0;
            sel2        <= 1'b0;
            in          <= 1'b0;
            route_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            pcnt        <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nx;
            in          <= 1'b0;
            route_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            if (rx_valid) begin
                if (start) begin
                    msb <= rx_bit;
                    err <= state != IDLE;
                end else if (state == ADDR1) begin
                    sel1 <= msb;
                    sel2 <= rx_bit;
                    pcnt <= '0;
                end else if (state == PAYLOAD) begin
                    in          <= rx_bit;
                    route_valid <= 1'b1;
                    pcnt        <= pcnt + 1'b1;
                    if (last) begin
                        frame_done       <= 1'b1;
                        cnt[{sel1, sel2}] <= cnt[{sel1, sel2}] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_demux_frame_ctrl.sv
// tb_demux_frame_ctrl: directed frames with a scoreboard queue of expected
// {route_valid,in,sel1,sel2,frame_done,err} events, popped by an output monitor.
module tb_demux_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_bit = 1'b0;
    logic       start = 1'b0;
    logic       in, sel1, sel2, route_valid, frame_done, err, busy;
    logic [7:0] ch_count;

    int errors = 0;
    int checks = 0;
    logic [5:0] q[$];

    demux_frame_ctrl #(.PAYLOAD_LEN(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .start(start),
        .in(in), .sel1(sel1), .sel2(sel2), .route_valid(route_valid),
        .frame_done(frame_done), .err(err), .busy(busy), .ch_count(ch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic b);
        @(negedge clk);
        rx_valid = v;
        start    = s;
        rx_bit   = b;
    endtask

    // expected event: {route_valid, in, sel1, sel2, frame_done, err}
    task automatic send_frame(input logic [1:0] a, input logic [3:0] p);
        beat(1, 1, a[1]);
        beat(1, 0, a[0]);
        for (int i = 3; i >= 0; i--) begin
            beat(1, 0, p[i]);
            q.push_back({1'b1, p[i], a, i == 0, 1'b0});
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!route_valid) chk("in_zero_when_idle", in, 0);
            if (route_valid || err || frame_done) begin
                if (q.size() == 0) chk("unexpected_output", {route_valid, in, sel1, sel2, frame_done, err}, 0);
                else chk("scoreboard", {route_valid, in, sel1, sel2, frame_done, err}, q.pop_front());
            end
        end
    end

    logic [7:0] wrap_exp[4] = '{8'h25, 8'h29, 8'h2D, 8'h21};

    initial begin
        #12;
        chk("reset_outs", {in, sel1, sel2, route_valid, frame_done, err, busy}, 0);
        chk("reset_cnt", ch_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // frame to channel 2, payload 1011
        beat(1, 1, 1);
        settle();
        chk("busy_after_start", busy, 1);
        beat(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            beat(1, 0, 4'b1011 >> (3 - i));
            q.push_back({1'b1, 1'(4'b1011 >> (3 - i)), 2'b10, i == 3, 1'b0});
        end
        beat(0, 0, 0);
        settle();
        chk("cnt_after_f1", ch_count, 8'h10);
        chk("sel_hold_f1", {sel1, sel2}, 2'b10);
        chk("busy_after_f1", busy, 0);

        // same frame with a 3-cycle stall after the second payload bit
        beat(1, 1, 1);
        beat(1, 0, 0);
        beat(1, 0, 1); q.push_back({1'b1, 1'b1, 2'b10, 1'b0, 1'b0});
        beat(1, 0, 0); q.push_back({1'b1, 1'b0, 2'b10, 1'b0, 1'b0});
        repeat (3) beat(0, 0, 1);
        settle();
        chk("stall_busy", busy, 1);
        beat(1, 0, 1); q.push_back({1'b1, 1'b1, 2'b10, 1'b0, 1'b0});
        beat(1, 0, 1); q.push_back({1'b1, 1'b1, 2'b10, 1'b1, 1'b0});
        beat(0, 0, 0);
        settle();
        chk("cnt_after_gap", ch_count, 8'h20);

        // channel 3 frame aborted by start after two payload bits
        beat(1, 1, 1);
        beat(1, 0, 1);
        beat(1, 0, 1); q.push_back({1'b1, 1'b1, 2'b11, 1'b0, 1'b0});
        beat(1, 0, 0); q.push_back({1'b1, 1'b0, 2'b11, 1'b0, 1'b0});
        beat(1, 1, 0); q.push_back({1'b0, 1'b0, 2'b11, 1'b0, 1'b1});
        beat(0, 0, 0);
        settle();
        chk("abort_busy", busy, 1);
        chk("abort_cnt", ch_count, 8'h20);
        beat(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            beat(1, 0, 4'b0110 >> (3 - i));
            q.push_back({1'b1, 1'(4'b0110 >> (3 - i)), 2'b00, i == 3, 1'b0});
        end
        beat(0, 0, 0);
        settle();
        chk("cnt_after_abort", ch_count, 8'h21);
        chk("sel_after_abort", {sel1, sel2}, 2'b00);

        // non-start beats while idle are discarded
        repeat (3) beat(1, 0, 1);
        beat(0, 0, 0);
        settle();
        chk("idle_busy", busy, 0);
        chk("idle_cnt", ch_count, 8'h21);

        // back-to-back frames to channel 1: 2-bit counter wraps
        for (int k = 0; k < 4; k++) begin
            send_frame(2'b01, 4'(4'b1100 ^ k));
            settle();
            chk($sformatf("wrap_cnt%0d", k), ch_count, wrap_exp[k]);
        end
        beat(0, 0, 0);

        // asynchronous reset in the middle of a payload
        beat(1, 1, 1);
        beat(1, 0, 1);
        beat(1, 0, 0); q.push_back({1'b1, 1'b0, 2'b11, 1'b0, 1'b0});
        beat(1, 0, 1);
        settle();
        chk("pre_reset_rv", {route_valid, in}, 2'b11);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {in, sel1, sel2, route_valid, busy}, 0);
        chk("async_reset_cnt", ch_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(2'b10, 4'b0101);
        beat(0, 0, 0);
        settle();
        chk("cnt_after_reset", ch_count, 8'h10);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
